// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC and issues single-outstanding word reads to
// instruction memory. Responses are buffered in a small FIFO that drains to the core over
// valid/ready. Redirects flush buffered and in-flight fetches.
module inst_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              imem_err,
  output logic              out_valid,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_fault,
  input  logic              out_ready
);

  localparam int unsigned      PTR_W   = $clog2(DEPTH);
  localparam int unsigned      CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDrain, StHalt} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  // Misaligned redirect seen while a stale response was still pending.
  logic              halt_pend_q, halt_pend_d;

  logic [ADDR_W-1:0] fifo_pc_q    [DEPTH];
  logic [INST_W-1:0] fifo_inst_q  [DEPTH];
  logic              fifo_fault_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic              push_resp;
  logic              pop;
  logic              outstanding;
  logic              misaligned;
  logic [CNT_W-1:0]  count_after;

  assign push_resp   = (state_q == StWait) && imem_rvalid;
  assign pop         = out_valid && out_ready;
  assign count_after = count_q + CNT_W'(push_resp) - CNT_W'(pop);
  assign misaligned  = redirect_pc[1:0] != 2'b00;
  // A request is still owed a response after this cycle: waiting with no rvalid yet, or
  // being granted right now.
  assign outstanding = ((state_q == StWait || state_q == StDrain) && !imem_rvalid) ||
                       (state_q == StReq && imem_gnt);

  assign out_valid = count_q != '0;
  assign out_inst  = fifo_inst_q[rd_ptr_q];
  assign out_pc    = fifo_pc_q[rd_ptr_q];
  assign out_fault = fifo_fault_q[rd_ptr_q];

  // Next-state, fetch PC and memory request generation; redirect overrides everything.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    halt_pend_d = halt_pend_q;
    imem_req    = 1'b0;
    imem_addr   = '0;
    unique case (state_q)
      StIdle: begin
        if (count_q < DEPTH_C) state_d = StReq;
      end
      StReq: begin
        imem_req  = 1'b1;
        imem_addr = fetch_pc_q;
        if (imem_gnt) begin
          fetch_pc_d = fetch_pc_q + ADDR_W'(4);
          state_d    = StWait;
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          if (imem_err)                  state_d = StHalt;
          else if (count_after < DEPTH_C) state_d = StReq;
          else                           state_d = StIdle;
        end
      end
      StDrain: begin
        if (imem_rvalid) state_d = halt_pend_q ? StHalt : StReq;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (redirect_valid) begin
      fetch_pc_d  = {redirect_pc[ADDR_W-1:2], 2'b00};
      halt_pend_d = misaligned;
      if (outstanding)     state_d = StDrain;
      else if (misaligned) state_d = StHalt;
      else                 state_d = StReq;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      fetch_pc_q  <= RESET_PC;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  // Response FIFO: flush (optionally seeding a misaligned-redirect fault) or push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_pc_q    <= '{default: '0};
      fifo_inst_q  <= '{default: '0};
      fifo_fault_q <= '{default: 1'b0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else if (redirect_valid) begin
      rd_ptr_q <= '0;
      if (misaligned) begin
        fifo_pc_q[0]    <= redirect_pc;
        fifo_inst_q[0]  <= '0;
        fifo_fault_q[0] <= 1'b1;
        wr_ptr_q        <= PTR_W'(1);
        count_q         <= CNT_W'(1);
      end else begin
        wr_ptr_q <= '0;
        count_q  <= '0;
      end
    end else begin
      if (push_resp) begin
        fifo_pc_q[wr_ptr_q]    <= fetch_pc_q - ADDR_W'(4);
        fifo_inst_q[wr_ptr_q]  <= imem_rdata;
        fifo_fault_q[wr_ptr_q] <= imem_err;
        wr_ptr_q               <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_after;
    end
  end

endmodule
